// File: rtl/multi_hash_bloom_filter.sv
// Counting Bloom filter with time-bucketed counters for flow latency measurement.
// Each request reads NUM_HASHES SRAM lines, updates one bucket counter per line and
// writes the lines back. Data packets increment the current time bucket; ack packets
// search backwards from the current bucket for the newest nonzero counter, decrement it
// and report its age (latency) as a two-word measurement record.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   in_wr/in_rdy                 request push into input FIFO / FIFO not full
//   is_ack, index, tuple         request fields (index k in slice k)
//   cur_bucket                   current time bucket, sampled at request start
//   rd_req/rd_addr/rd_ack        SRAM read request handshake
//   rd_vld/rd_data               SRAM read return, in request order
//   wr_req/wr_addr/wr_data/wr_ack  SRAM write handshake
//   out_wr/out_data/out_rdy      64-bit measurement stream
//   fp_count                     count of mismatching or missing ack measurements
module multi_hash_bloom_filter #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int NUM_BITS_BUCKET = 4,
  parameter int RESERVED        = 16,
  parameter int NUM_HASHES      = 2,
  parameter int FIFO_DEPTH_BITS = 3,
  localparam int NB = (SRAM_DATA_WIDTH - RESERVED) / NUM_BITS_BUCKET,
  localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_wr,
  output logic                                  in_rdy,
  input  logic                                  is_ack,
  input  logic [NUM_HASHES*SRAM_ADDR_WIDTH-1:0] index,
  input  logic [95:0]                           tuple,
  input  logic [BW-1:0]                         cur_bucket,
  output logic                                  rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0]            rd_addr,
  input  logic                                  rd_ack,
  input  logic                                  rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0]            rd_data,
  output logic                                  wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0]            wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0]            wr_data,
  input  logic                                  wr_ack,
  output logic                                  out_wr,
  output logic [63:0]                           out_data,
  input  logic                                  out_rdy,
  output logic [31:0]                           fp_count
);

  localparam int IdxW   = NUM_HASHES * SRAM_ADDR_WIDTH;
  localparam int EntryW = 1 + 96 + IdxW;
  localparam int Depth  = 1 << FIFO_DEPTH_BITS;
  localparam logic [NUM_BITS_BUCKET-1:0] BucketMax = '1;

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StModify, StWrReq, StEmit0, StEmit1, StPop
  } state_e;

  state_e state_q, state_d;

  // Input FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [EntryW-1:0]        mem_q [Depth];
  logic [FIFO_DEPTH_BITS:0] wptr_q, rptr_q;
  logic                     full, empty, push, pop;

  assign full   = (wptr_q ^ rptr_q) == {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
  assign empty  = wptr_q == rptr_q;
  assign push   = in_wr & ~full;
  assign pop    = state_q == StPop;
  assign in_rdy = reset & ~full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_DEPTH_BITS-1:0]] <= {is_ack, tuple, index};
  end

  // Head entry stays in the FIFO until StPop, so it is stable for the whole request.
  logic [EntryW-1:0] head;
  logic              head_ack;
  logic [95:0]       head_tuple;
  assign head       = mem_q[rptr_q[FIFO_DEPTH_BITS-1:0]];
  assign head_ack   = head[EntryW-1];
  assign head_tuple = head[EntryW-2 -: 96];

  logic [SRAM_ADDR_WIDTH-1:0] idx   [NUM_HASHES];
  logic [NUM_HASHES-1:0]      dup;
  int unsigned                first [NUM_HASHES];

  // Duplicate detection: first[k] is the lowest index carrying the same address.
  always_comb begin
    for (int k = 0; k < NUM_HASHES; k++) begin
      idx[k]   = head[k*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
    end
    for (int k = 0; k < NUM_HASHES; k++) begin
      dup[k]   = 1'b0;
      first[k] = k;
      for (int i = NUM_HASHES - 1; i >= 0; i--) begin
        if (i < k && idx[i] == idx[k]) begin
          dup[k]   = 1'b1;
          first[k] = i;
        end
      end
    end
  end

  logic [BW-1:0]              cb_q;
  logic [2:0]                 rd_cnt_q, ret_cnt_q, wr_cnt_q;
  logic [SRAM_DATA_WIDTH-1:0] line_q   [NUM_HASHES];
  logic [BW-1:0]              lat_q    [NUM_HASHES];
  logic [NUM_HASHES-1:0]      miss_q;
  logic [31:0]                fp_q;

  logic [SRAM_DATA_WIDTH-1:0] new_line [NUM_HASHES];
  logic [BW-1:0]              new_lat  [NUM_HASHES];
  logic [NUM_HASHES-1:0]      new_miss;
  int unsigned                cb_mod;

  assign cb_mod = 32'(cb_q) % NB;

  // Bucket update. Only bucket fields are touched, so reserved and spare bits pass
  // through. A miss leaves the line unchanged and reports latency 0.
  always_comb begin
    for (int k = 0; k < NUM_HASHES; k++) begin
      new_line[k] = line_q[k];
      new_lat[k]  = '0;
      new_miss[k] = 1'b1;
      if (!head_ack) begin
        new_miss[k] = 1'b0;
        if (line_q[k][RESERVED + cb_mod*NUM_BITS_BUCKET +: NUM_BITS_BUCKET] != BucketMax) begin
          new_line[k][RESERVED + cb_mod*NUM_BITS_BUCKET +: NUM_BITS_BUCKET] =
            line_q[k][RESERVED + cb_mod*NUM_BITS_BUCKET +: NUM_BITS_BUCKET] +
            NUM_BITS_BUCKET'(1);
        end
      end else begin
        for (int d = 0; d < NB; d++) begin
          if (new_miss[k] &&
              line_q[k][RESERVED + ((cb_mod + NB - d) % NB)*NUM_BITS_BUCKET +: NUM_BITS_BUCKET]
              != '0) begin
            new_miss[k] = 1'b0;
            new_lat[k]  = BW'(d);
            new_line[k][RESERVED + ((cb_mod + NB - d) % NB)*NUM_BITS_BUCKET +: NUM_BITS_BUCKET] =
              line_q[k][RESERVED + ((cb_mod + NB - d) % NB)*NUM_BITS_BUCKET +: NUM_BITS_BUCKET]
              - NUM_BITS_BUCKET'(1);
          end
        end
      end
    end
    // A duplicate line is only modified once; it inherits the first copy's result.
    for (int k = 0; k < NUM_HASHES; k++) begin
      if (dup[k]) begin
        new_lat[k]  = new_lat[first[k]];
        new_miss[k] = new_miss[first[k]];
      end
    end
  end

  logic [SRAM_ADDR_WIDTH-1:0] cur_raddr, cur_waddr;
  logic [SRAM_DATA_WIDTH-1:0] cur_wdata;
  logic                       cur_dup, wr_done, match;

  always_comb begin
    cur_raddr = '0;
    cur_waddr = '0;
    cur_wdata = '0;
    cur_dup   = 1'b0;
    match     = 1'b1;
    for (int k = 0; k < NUM_HASHES; k++) begin
      if (rd_cnt_q == 3'(k)) cur_raddr = idx[k];
      if (wr_cnt_q == 3'(k)) begin
        cur_waddr = idx[k];
        cur_wdata = line_q[k];
        cur_dup   = dup[k];
      end
      if (miss_q[k] || lat_q[k] != lat_q[0]) match = 1'b0;
    end
  end

  // Duplicate slots are skipped without a write handshake.
  assign wr_done = cur_dup | wr_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StRdReq;
      StRdReq:  if (rd_ack && rd_cnt_q == 3'(NUM_HASHES - 1)) state_d = StRdWait;
      StRdWait: if (ret_cnt_q == 3'(NUM_HASHES)) state_d = StModify;
      StModify: state_d = StWrReq;
      StWrReq: begin
        if (wr_done && wr_cnt_q == 3'(NUM_HASHES - 1)) state_d = head_ack ? StEmit0 : StPop;
      end
      StEmit0:  if (out_rdy) state_d = StEmit1;
      StEmit1:  if (out_rdy) state_d = StPop;
      StPop:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cb_q      <= '0;
      rd_cnt_q  <= '0;
      ret_cnt_q <= '0;
      wr_cnt_q  <= '0;
      miss_q    <= '0;
      fp_q      <= '0;
      for (int k = 0; k < NUM_HASHES; k++) begin
        line_q[k] <= '0;
        lat_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (state_q == StIdle && !empty) begin
        cb_q      <= cur_bucket;
        rd_cnt_q  <= '0;
        ret_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end
      if (state_q == StRdReq && rd_ack) rd_cnt_q <= rd_cnt_q + 3'd1;
      if ((state_q == StRdReq || state_q == StRdWait) && rd_vld &&
          ret_cnt_q < 3'(NUM_HASHES)) begin
        for (int k = 0; k < NUM_HASHES; k++) begin
          if (ret_cnt_q == 3'(k)) line_q[k] <= rd_data;
        end
        ret_cnt_q <= ret_cnt_q + 3'd1;
      end
      if (state_q == StModify) begin
        line_q <= new_line;
        lat_q  <= new_lat;
        miss_q <= new_miss;
      end
      if (state_q == StWrReq && wr_done) wr_cnt_q <= wr_cnt_q + 3'd1;
      if (state_q == StEmit1 && out_rdy && !match && fp_q != '1) fp_q <= fp_q + 32'd1;
    end
  end

  assign rd_req   = state_q == StRdReq;
  assign rd_addr  = rd_req ? cur_raddr : '0;
  assign wr_req   = state_q == StWrReq && !cur_dup;
  assign wr_addr  = wr_req ? cur_waddr : '0;
  assign wr_data  = wr_req ? cur_wdata : '0;
  assign out_wr   = state_q == StEmit0 || state_q == StEmit1;
  assign out_data = (state_q == StEmit0) ? head_tuple[95:32] :
                    (state_q == StEmit1) ? {head_tuple[31:0], match, 15'b0, 16'(lat_q[0])} :
                    64'd0;
  assign fp_count = fp_q;

endmodule

// File: tb/tb_multi_hash_bloom_filter.sv
module tb_multi_hash_bloom_filter;
  localparam int AW = 19, DW = 72, NBB = 4, RES = 16, NH = 2, FDB = 3;
  localparam int NB = 14, BW = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic in_wr = 1'b0, in_rdy, is_ack = 1'b0;
  logic [NH*AW-1:0] index = '0;
  logic [95:0] tuple = '0;
  logic [BW-1:0] cur_bucket = '0;
  logic rd_req, rd_ack = 1'b0, rd_vld = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, wr_data;
  logic wr_req, wr_ack = 1'b0, out_wr, out_rdy = 1'b0;
  logic [63:0] out_data;
  logic [31:0] fp_count;

  always #5 clk = ~clk;

  multi_hash_bloom_filter #(
    .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .NUM_BITS_BUCKET(NBB), .RESERVED(RES),
    .NUM_HASHES(NH), .FIFO_DEPTH_BITS(FDB)
  ) dut (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_rdy(in_rdy), .is_ack(is_ack),
    .index(index), .tuple(tuple), .cur_bucket(cur_bucket),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .out_wr(out_wr), .out_data(out_data), .out_rdy(out_rdy), .fp_count(fp_count)
  );

  bit [DW-1:0] sram [int unsigned];
  bit [DW-1:0] ref_mem [int unsigned];
  int unsigned exp_wa[$];
  bit [DW-1:0] exp_wd[$];
  bit [63:0] exp_out[$], exp_msk[$];
  int unsigned rdq[$];
  int n_cmp = 0, n_err = 0;
  int unsigned fp_model = 0;
  int cb = 0;
  bit wr_stall = 0, hold_out = 0;
  bit [63:0] oe, om;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [DW-1:0] sram_get(input int unsigned a);
    return sram.exists(a) ? sram[a] : '0;
  endfunction

  function automatic bit [DW-1:0] ref_get(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Reference model: buckets as plain integers, lines handled once per distinct address.
  task automatic model(input bit ack, input int unsigned a0, input int unsigned a1,
                       input bit [95:0] tup);
    int unsigned a[NH];
    int lat[NH];
    bit miss[NH];
    int b[NB];
    int dupi, p;
    bit match;
    bit [DW-1:0] line;
    a[0] = a0;
    a[1] = a1;
    for (int k = 0; k < NH; k++) begin
      dupi = -1;
      for (int i = 0; i < k; i++) if (a[i] == a[k] && dupi < 0) dupi = i;
      if (dupi >= 0) begin
        lat[k] = lat[dupi];
        miss[k] = miss[dupi];
      end else begin
        line = ref_get(a[k]);
        for (int j = 0; j < NB; j++) b[j] = int'(line[RES + NBB*j +: NBB]);
        lat[k] = 0;
        miss[k] = 0;
        if (!ack) begin
          if (b[cb] < 15) b[cb] = b[cb] + 1;
        end else begin
          miss[k] = 1;
          for (int d = 0; d < NB && miss[k]; d++) begin
            p = (cb - d + NB) % NB;
            if (b[p] != 0) begin
              b[p] = b[p] - 1;
              lat[k] = d;
              miss[k] = 0;
            end
          end
        end
        for (int j = 0; j < NB; j++) line[RES + NBB*j +: NBB] = 4'(b[j]);
        ref_mem[a[k]] = line;
        exp_wa.push_back(a[k]);
        exp_wd.push_back(line);
      end
    end
    if (ack) begin
      match = 1;
      for (int k = 0; k < NH; k++) if (miss[k] || lat[k] != lat[0]) match = 0;
      exp_out.push_back(tup[95:32]);
      exp_msk.push_back('1);
      exp_out.push_back({tup[31:0], match, 15'b0, 16'(lat[0])});
      // Latency on a miss is not defined, so that field is left unchecked.
      exp_msk.push_back(miss[0] ? 64'hFFFF_FFFF_FFFF_0000 : 64'hFFFF_FFFF_FFFF_FFFF);
      if (!match && fp_model != 32'hFFFF_FFFF) fp_model++;
    end
  endtask

  // SRAM and output-sink responder; every write and output word is scoreboarded here.
  always @(negedge clk) begin
    if (!reset) begin
      rd_ack = 0;
      rd_vld = 0;
      wr_ack = 0;
      out_rdy = 0;
      rdq.delete();
    end else begin
      rd_vld = 0;
      if (rdq.size() != 0 && $urandom_range(0, 1) == 1) begin
        rd_vld = 1;
        rd_data = sram_get(rdq.pop_front());
      end
      if (rd_ack) rd_ack = 0;
      else if (rd_req && $urandom_range(0, 2) != 0) begin
        rd_ack = 1;
        rdq.push_back(rd_addr);
      end
      if (wr_ack) wr_ack = 0;
      else if (wr_req && !wr_stall && $urandom_range(0, 2) != 0) begin
        wr_ack = 1;
        chk("wr_expected", exp_wa.size() != 0, 1);
        if (exp_wa.size() != 0) begin
          chk("wr_addr", wr_addr, exp_wa.pop_front());
          chk("wr_data", wr_data, exp_wd.pop_front());
        end
        sram[wr_addr] = wr_data;
      end
      out_rdy = 0;
      if (out_wr && !hold_out && $urandom_range(0, 1) == 1) begin
        out_rdy = 1;
        chk("out_expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) begin
          oe = exp_out.pop_front();
          om = exp_msk.pop_front();
          chk("out_data", out_data & om, oe & om);
        end
      end
    end
  end

  task automatic push(input bit ack, input int unsigned a0, input int unsigned a1,
                      input bit [95:0] tup);
    @(negedge clk);
    in_wr = 1;
    is_ack = ack;
    index = {AW'(a1), AW'(a0)};
    tuple = tup;
    if (in_rdy) model(ack, a0, a1, tup);
    @(negedge clk);
    in_wr = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_wa.size() != 0 || exp_out.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_wa.size() + exp_out.size(), 0);
    repeat (4) @(negedge clk);
    chk("fp_count", fp_count, fp_model);
    chk("in_rdy_idle", in_rdy, 1);
  endtask

  function automatic bit [95:0] rtup();
    return {$urandom, $urandom, $urandom};
  endfunction

  bit [DW-1:0] saved, snap_line;
  bit [63:0] snap;
  int t;

  initial begin
    for (int unsigned a = 0; a < 32; a++) sram[a] = {$urandom, $urandom, $urandom};
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fp", fp_count, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    chk("in_rdy_after_rst", in_rdy, 1);

    // Data request on zero lines.
    sram[5] = '0;
    sram[9] = '0;
    ref_mem = sram;
    cb = 3;
    cur_bucket = 4'(cb);
    push(0, 5, 9, rtup());
    drain();
    chk("t1_line5", sram_get(5), 72'h1 << 28);
    chk("t1_line9", sram_get(9), 72'h1 << 28);

    // Saturation at 15 with other bits preserved.
    saved = {$urandom, $urandom, $urandom};
    saved[28 +: 4] = 4'hF;
    sram[5] = saved;
    ref_mem = sram;
    push(0, 5, 9, rtup());
    drain();
    chk("t2_sat", sram_get(5), saved);

    // Ack with matching latency 3.
    sram[5] = 72'h1 << 28;
    sram[9] = 72'h1 << 28;
    ref_mem = sram;
    cb = 6;
    cur_bucket = 4'(cb);
    push(1, 5, 9, rtup());
    drain();
    chk("t3_clr5", sram_get(5), 0);
    chk("t3_clr9", sram_get(9), 0);
    chk("t3_fp", fp_count, 0);

    // Mismatching latencies 2 and 4.
    sram[5] = 72'h1 << (RES + 16);
    sram[9] = 72'h1 << (RES + 8);
    ref_mem = sram;
    push(1, 5, 9, rtup());
    drain();
    chk("t4_fp", fp_count, 1);

    // Wrap-around search: cb=1, bucket 12 -> latency 3.
    sram[5] = 72'h1 << (RES + 48);
    sram[9] = 72'h1 << (RES + 48);
    ref_mem = sram;
    cb = 1;
    cur_bucket = 4'(cb);
    push(1, 5, 9, rtup());
    drain();

    // Duplicate index: single write.
    snap_line = sram_get(7);
    push(0, 7, 7, rtup());
    drain();
    chk("t5_dup_line", sram_get(7), ref_get(7));

    // Output held while out_rdy stays low.
    hold_out = 1;
    push(1, 7, 3, rtup());
    t = 0;
    while (!out_wr && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t6_emit_seen", out_wr, 1);
    snap = out_data;
    chk("t6_emit0", snap, exp_out[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_wr", out_wr, 1);
      chk("t6_hold_data", out_data, snap);
    end
    hold_out = 0;
    drain();

    // FIFO full: stall writes so the head cannot retire.
    wr_stall = 1;
    cb = 9;
    cur_bucket = 4'(cb);
    for (int i = 0; i < 8; i++) push(0, $urandom_range(0, 31), $urandom_range(0, 31), rtup());
    chk("t7_full", in_rdy, 0);
    push(0, 1, 2, rtup());
    chk("t7_still_full", in_rdy, 0);
    wr_stall = 0;
    drain();

    // Reset during a pending write.
    wr_stall = 1;
    push(0, 5, 9, rtup());
    t = 0;
    while (!wr_req && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t8_wr_seen", wr_req, 1);
    #2;
    reset = 0;
    #1;
    chk("t8_wr_req", wr_req, 0);
    chk("t8_wr_addr", wr_addr, 0);
    chk("t8_wr_data", wr_data, 0);
    chk("t8_rd_req", rd_req, 0);
    chk("t8_out_wr", out_wr, 0);
    chk("t8_in_rdy", in_rdy, 0);
    chk("t8_fp", fp_count, 0);
    exp_wa.delete();
    exp_wd.delete();
    exp_out.delete();
    exp_msk.delete();
    ref_mem = sram;
    fp_model = 0;
    wr_stall = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    push(1, 11, 12, rtup());
    push(0, 11, 13, rtup());
    drain();

    // Randomized bursts sharing one time bucket each.
    for (int r = 0; r < 30; r++) begin
      cb = $urandom_range(0, NB - 1);
      cur_bucket = 4'(cb);
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        push(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15), rtup());
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_hash_bloom_filter.md
MULTI_HASH_BLOOM_FILTER -- requirements
Module: multi_hash_bloom_filter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 19, SRAM word address width.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 72, SRAM line width.
REQ-003 SHALL have parameter NUM_BITS_BUCKET, default 4, width of one bucket counter.
REQ-004 SHALL have parameter RESERVED, default 16, number of low line bits preserved untouched.
REQ-005 SHALL have parameter NUM_HASHES, default 2, range 1..4, hash indices (SRAM lines) per request.
REQ-006 SHALL have parameter FIFO_DEPTH_BITS, default 3, log2 of input FIFO depth.
REQ-007 SHALL use derived values NB = (SRAM_DATA_WIDTH-RESERVED)/NUM_BITS_BUCKET and BW = ceil(log2(NB)); bucket i occupies line bits [RESERVED+(i+1)*NUM_BITS_BUCKET-1 : RESERVED+i*NUM_BITS_BUCKET].
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-010 in_wr  in  1  push request into input FIFO.
REQ-011 in_rdy  out  1  input FIFO not full.
REQ-012 is_ack  in  1  1 = ack packet (decrement/measure), 0 = data packet (increment).
REQ-013 index  in  NUM_HASHES*SRAM_ADDR_WIDTH  hash addresses; index k in slice k.
REQ-014 tuple  in  96  {src_ip, dst_ip, src_port, dst_port}.
REQ-015 cur_bucket  in  BW  current time bucket, from external shifter.
REQ-016 rd_req / rd_addr / rd_ack  out / out / in  1 / SRAM_ADDR_WIDTH / 1  SRAM read request, held until rd_ack.
REQ-017 rd_vld / rd_data  in / in  1 / SRAM_DATA_WIDTH  read data return, in request order.
REQ-018 wr_req / wr_addr / wr_data / wr_ack  out / out / out / in  1 / SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH / 1  SRAM write, held until wr_ack.
REQ-019 out_wr / out_data / out_rdy  out / out / in  1 / 64 / 1  measurement word stream; transfer when out_wr & out_rdy.
REQ-020 fp_count  out  32  count of acks whose per-hash latencies disagreed or found no bucket.

Function
REQ-021 Input FIFO SHALL store {is_ack, tuple, index}, depth 2^FIFO_DEPTH_BITS; in_wr while full SHALL be ignored.
REQ-022 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, EMIT0, EMIT1, POP; one request processed at a time.
REQ-023 IDLE -> RD_REQ when FIFO non-empty; cur_bucket SHALL be sampled into cb_q at this transition and held for the whole request.
REQ-024 RD_REQ SHALL issue reads for index 0..NUM_HASHES-1 in order, rd_req held per address until rd_ack, then RD_WAIT.
REQ-025 RD_WAIT SHALL capture rd_vld data into line register k (k counting returns, including returns arriving during RD_REQ), then MODIFY after NUM_HASHES returns.
REQ-026 MODIFY (one cycle), data request: bucket cb_q of each line incremented, saturating at 2^NUM_BITS_BUCKET-1.
REQ-027 MODIFY, ack request: per line search buckets cb_q, cb_q-1, ... circularly modulo NB for first nonzero; decrement it; lat_k = (cb_q - found) mod NB; none found -> line unchanged, miss_k = 1.
REQ-028 Line bits [RESERVED-1:0] and bits above RESERVED+NB*NUM_BITS_BUCKET-1 SHALL be written back unchanged.
REQ-029 Duplicate index (index j equals an earlier index i) SHALL modify and write that line once; lat_j = lat_i, miss_j = miss_i.
REQ-030 WR_REQ SHALL write non-duplicate lines in index order, wr_req held until wr_ack; data requests then -> POP, acks -> EMIT0.
REQ-031 EMIT0 SHALL present out_data = tuple[95:32]; EMIT1 SHALL present {tuple[31:0], match, 15'b0, 16-bit zero-extended lat_0}; each state held until out_rdy.
REQ-032 match = 1 iff no miss_k and all lat_k equal; match = 0 SHALL increment fp_count (saturating at 2^32-1) on EMIT1 transfer.
REQ-033 POP SHALL dequeue the FIFO head for one cycle and return to IDLE; minimum idle-to-idle time is not specified.
REQ-034 rd_vld while not in RD_REQ/RD_WAIT SHALL be ignored.

Reset
REQ-035 reset low SHALL immediately force IDLE, empty FIFO, rd_req=wr_req=out_wr=0, rd_addr=wr_addr=wr_data=out_data=0, fp_count=0, in_rdy=0 while asserted; in-flight SRAM transactions abandoned.

Verification
REQ-036 Data req, NUM_HASHES=2, index {5,9}, cb=3, lines zero -> writes addr 5,9 with bucket 3 = 1 each, no out_wr.
REQ-037 Bucket 3 = 15, data req cb=3 -> written bucket stays 15, other bits unchanged.
REQ-038 Ack, index {5,9}, cb=6, both lines bucket 3 = 1 -> buckets cleared, EMIT1 lat=3, match=1, fp_count=0.
REQ-039 Ack, line 5 nonzero only bucket 4, line 9 only bucket 2, cb=6 -> match=0, lat=2, fp_count=1; wrap: cb=1, nonzero bucket 12 (NB=14) -> lat=3.
REQ-040 Duplicate index {7,7} data req -> exactly one write to 7, bucket +1; out_rdy low 10 cycles in EMIT0 -> out_data held stable.
REQ-041 reset low during WR_REQ -> wr_req drops asynchronously, FSM IDLE, subsequent request processed normally.
